// File: rtl/median_sort_pipe.sv
// Purpose: N-lane ascending sorter (odd-even transposition network) with median tap; MEDIAN_SIGNED_EN selects signed compares.
// Latency: ceil(N/REG_STRIDE) cycles from input accept to out_valid; one vector per cycle sustained.
// Backpressure: whole pipe stalls when out_valid & ~out_ready; in_ready = out_ready | ~out_valid.
module median_sort_pipe #(
    parameter int N          = 11,
    parameter int W          = 32,
    parameter int REG_STRIDE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data,
    output logic [W-1:0]   out_median
);
    localparam int LATENCY = (N + REG_STRIDE - 1) / REG_STRIDE;
    localparam int MID     = (N - 1) / 2;

    logic [N*W-1:0]   r_slot_dat [LATENCY];
    logic [LATENCY-1:0] r_slot_vld;
    logic [N*W-1:0]   w_slot_nxt [LATENCY];
    logic [LATENCY-1:0] w_vld_nxt;
    logic             w_en;

    // Strict greater-than keeps equal lanes in place, so ties never swap.
    function automatic logic f_gt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MEDIAN_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // The whole pipe moves together; it only freezes when the head is full and not taken.
    assign w_en       = out_ready | ~r_slot_vld[LATENCY-1];
    assign in_ready   = w_en;
    assign out_valid  = r_slot_vld[LATENCY-1];
    assign out_data   = r_slot_dat[LATENCY-1];
    assign out_median = r_slot_dat[LATENCY-1][MID*W +: W];

    genvar s, i, k;
    generate
        for (s = 0; s < N; s++) begin : gen_stage
            logic [N*W-1:0] w_in;
            logic [N*W-1:0] w_out;

            // First stage of a slot reads the previous slot register (or the input); others chain.
            if ((s % REG_STRIDE) != 0) begin : g_chain
                assign w_in = gen_stage[s-1].w_out;
            end else if (s == 0) begin : g_head
                assign w_in = in_data;
            end else begin : g_reg
                assign w_in = r_slot_dat[s/REG_STRIDE - 1];
            end

            for (i = 0; i < N; i++) begin : gen_lane
                if (((i % 2) == (s % 2)) && (i + 1 < N)) begin : g_lo
                    assign w_out[i*W +: W] = f_gt(w_in[i*W +: W], w_in[(i+1)*W +: W])
                                             ? w_in[(i+1)*W +: W] : w_in[i*W +: W];
                end else if ((i > 0) && (((i - 1) % 2) == (s % 2))) begin : g_hi
                    assign w_out[i*W +: W] = f_gt(w_in[(i-1)*W +: W], w_in[i*W +: W])
                                             ? w_in[(i-1)*W +: W] : w_in[i*W +: W];
                end else begin : g_pass
                    assign w_out[i*W +: W] = w_in[i*W +: W];
                end
            end

            // Last stage belonging to a slot feeds that slot's register.
            if (((s % REG_STRIDE) == (REG_STRIDE - 1)) || (s == N - 1)) begin : g_tap
                assign w_slot_nxt[s/REG_STRIDE] = w_out;
            end
        end

        for (k = 0; k < LATENCY; k++) begin : gen_vld
            if (k == 0) begin : g_first
                assign w_vld_nxt[k] = in_valid;
            end else begin : g_next
                assign w_vld_nxt[k] = r_slot_vld[k-1];
            end
        end
    endgenerate

    // Slot registers: reset clears data and valid, otherwise shift forward on enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_vld <= '0;
            for (int n = 0; n < LATENCY; n++) begin
                r_slot_dat[n] <= '0;
            end
        end else if (w_en) begin
            r_slot_vld <= w_vld_nxt;
            for (int n = 0; n < LATENCY; n++) begin
                r_slot_dat[n] <= w_slot_nxt[n];
            end
        end
    end

endmodule

// File: tb/tb_median_sort_pipe.sv
// Purpose: directed checks of median_sort_pipe at N=11/RS=2 plus N=4/RS=1 and N=11/RS=11 instances.
// Latency: expects 6, 4 and 1 cycles respectively.
// Backpressure: stalls the main instance via out_ready; the others run with out_ready tied high.
module tb_median_sort_pipe;
    typedef logic [351:0] vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    vec_t         in_data;
    logic         out_valid;
    logic         out_ready;
    vec_t         out_data;
    logic [31:0]  out_median;

    logic         in_ready4, o4_vld;
    logic [127:0] o4_dat;
    logic [31:0]  o4_med;
    logic         in_ready11, o11_vld;
    vec_t         o11_dat;
    logic [31:0]  o11_med;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;
    vec_t q_m[$];
    vec_t q_4[$];
    vec_t q_11[$];
    vec_t mon_e;

    median_sort_pipe #(.N(11), .W(32), .REG_STRIDE(2)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_median(out_median));

    median_sort_pipe #(.N(4), .W(32), .REG_STRIDE(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data[127:0]),
        .out_valid(o4_vld), .out_ready(1'b1), .out_data(o4_dat), .out_median(o4_med));

    median_sort_pipe #(.N(11), .W(32), .REG_STRIDE(11)) u_dut11 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready11), .in_data(in_data),
        .out_valid(o11_vld), .out_ready(1'b1), .out_data(o11_dat), .out_median(o11_med));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input vec_t got, input vec_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic lt(input logic [31:0] a, input logic [31:0] b);
`ifdef MEDIAN_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    // Reference: insertion sort of the first n lanes, upper lanes zero.
    function automatic vec_t f_sort(input vec_t v, input int n);
        logic [31:0] a [11];
        logic [31:0] t;
        vec_t r;
        r = '0;
        for (int x = 0; x < n; x++) a[x] = v[x*32 +: 32];
        for (int x = 1; x < n; x++) begin
            t = a[x];
            for (int y = x; y > 0; y--) begin
                if (lt(t, a[y-1])) begin
                    a[y]   = a[y-1];
                    a[y-1] = t;
                end
            end
        end
        for (int x = 0; x < n; x++) r[x*32 +: 32] = a[x];
        return r;
    endfunction

    // Scoreboards: transfers are decided at the next rising edge, so evaluate on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q_m.delete();
            q_4.delete();
            q_11.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (q_m.size() == 0) chk_eq("unexp_main", vec_t'(out_valid), vec_t'(0));
                else begin
                    mon_e = q_m.pop_front();
                    chk_eq("sb_main", out_data, mon_e);
                    chk_eq("sb_main_med", vec_t'(out_median), vec_t'(mon_e[5*32 +: 32]));
                end
            end
            if (o4_vld) begin
                if (q_4.size() == 0) chk_eq("unexp_n4", vec_t'(o4_vld), vec_t'(0));
                else begin
                    mon_e = q_4.pop_front();
                    chk_eq("sb_n4", vec_t'(o4_dat), mon_e);
                    chk_eq("sb_n4_med", vec_t'(o4_med), vec_t'(mon_e[1*32 +: 32]));
                end
            end
            if (o11_vld) begin
                if (q_11.size() == 0) chk_eq("unexp_rs11", vec_t'(o11_vld), vec_t'(0));
                else begin
                    mon_e = q_11.pop_front();
                    chk_eq("sb_rs11", o11_dat, mon_e);
                    chk_eq("sb_rs11_med", vec_t'(o11_med), vec_t'(mon_e[5*32 +: 32]));
                end
            end
            if (in_valid && in_ready)   q_m.push_back(f_sort(in_data, 11));
            if (in_valid && in_ready4)  q_4.push_back(f_sort(vec_t'(in_data[127:0]), 4));
            if (in_valid && in_ready11) q_11.push_back(f_sort(in_data, 11));
        end
    end

    task automatic send(input vec_t v);
        logic acc;
        int   guard;
        in_data  = v;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk_eq("send_timeout", vec_t'(acc), vec_t'(1));
        in_valid = 1'b0;
    endtask

    // Send one vector into an empty pipe and record when each instance first presents it.
    task automatic run_one(input vec_t v, output vec_t d, output logic [31:0] med,
                           output int lat_m, output int lat_4, output int lat_11, output int cnt_m);
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat_m = 0; lat_4 = 0; lat_11 = 0; cnt_m = 0;
        d = '0; med = '0;
        for (int c = 1; c <= 12; c++) begin
            if (out_valid) begin
                if (lat_m == 0) begin
                    lat_m = c;
                    d     = out_data;
                    med   = out_median;
                end
                cnt_m++;
            end
            if (o4_vld && lat_4 == 0)   lat_4 = c;
            if (o11_vld && lat_11 == 0) lat_11 = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q_m.size() + q_4.size() + q_11.size()) != 0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk_eq("drain_empty", vec_t'(q_m.size() + q_4.size() + q_11.size()), vec_t'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t        v, e, d;
        vec_t        bp [10];
        logic [31:0] med;
        int          lm, l4, l11, cm, c0, n0;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_out_valid", vec_t'(out_valid), vec_t'(0));
        chk_eq("rst_out_data", out_data, vec_t'(0));
        chk_eq("rst_out_median", vec_t'(out_median), vec_t'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("rst_in_ready", vec_t'(in_ready), vec_t'(1));
        out_ready = 1'b1;

        // 2: reversed vector, latency per instance
        v = '0; e = '0;
        for (int x = 0; x < 11; x++) begin
            v[x*32 +: 32] = 32'(10 - x);
            e[x*32 +: 32] = 32'(x);
        end
        run_one(v, d, med, lm, l4, l11, cm);
        chk_eq("t2_latency", vec_t'(lm), vec_t'(6));
        chk_eq("t2_valid_cycles", vec_t'(cm), vec_t'(1));
        chk_eq("t2_data", d, e);
        chk_eq("t2_median", vec_t'(med), vec_t'(5));
        chk_eq("t2_latency_n4", vec_t'(l4), vec_t'(4));
        chk_eq("t2_latency_rs11", vec_t'(l11), vec_t'(1));

        // 5: duplicates and sign
        v = '0;
        for (int x = 0; x < 11; x++) v[x*32 +: 32] = 32'd7;
        run_one(v, d, med, lm, l4, l11, cm);
        chk_eq("t5_all7_data", d, v);
        chk_eq("t5_all7_median", vec_t'(med), vec_t'(7));

        v = '0; e = '0;
        v[31:0] = 32'hFFFF_FFFF;
        for (int x = 1; x < 11; x++) v[x*32 +: 32] = 32'(x);
`ifdef MEDIAN_SIGNED_EN
        e = v;
`else
        for (int x = 0; x < 10; x++) e[x*32 +: 32] = 32'(x + 1);
        e[10*32 +: 32] = 32'hFFFF_FFFF;
`endif
        run_one(v, d, med, lm, l4, l11, cm);
        chk_eq("t5_sign_data", d, e);
`ifdef MEDIAN_SIGNED_EN
        chk_eq("t5_sign_median", vec_t'(med), vec_t'(5));
`else
        chk_eq("t5_sign_median", vec_t'(med), vec_t'(6));
`endif

        // 3: 200 back-to-back vectors, half the lanes small to force ties
        c0 = cyc;
        for (int n = 0; n < 200; n++) begin
            for (int x = 0; x < 11; x++)
                v[x*32 +: 32] = (x % 2 == 0) ? $urandom() : 32'($urandom_range(0, 7));
            send(v);
        end
        chk_eq("t3_burst_cycles", vec_t'(cyc - c0), vec_t'(200));
        drain();

        // 4: backpressure with a full pipe
        for (int n = 0; n < 10; n++)
            for (int x = 0; x < 11; x++) bp[n][x*32 +: 32] = $urandom();
        n0 = n_out;
        out_ready = 1'b0;
        for (int n = 0; n < 6; n++) send(bp[n]);
        chk_eq("t4_full_valid", vec_t'(out_valid), vec_t'(1));
        in_data  = bp[6];
        in_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            chk_eq("t4_stall_in_ready", vec_t'(in_ready), vec_t'(0));
            chk_eq("t4_stall_data", out_data, f_sort(bp[0], 11));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int n = 6; n < 10; n++) send(bp[n]);
        drain();
        chk_eq("t4_out_count", vec_t'(n_out - n0), vec_t'(10));

        // 6: mid-stream reset discards in-flight vectors
        for (int n = 0; n < 3; n++) send(bp[n]);
        n0  = n_out;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("t6_out_valid", vec_t'(out_valid), vec_t'(0));
        repeat (12) @(posedge clk);
        #1;
        chk_eq("t6_no_emerge", vec_t'(n_out - n0), vec_t'(0));
        chk_eq("t6_in_ready", vec_t'(in_ready), vec_t'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
